core_wb_regfile_sb: RTL and testbench
=====================================

Name: core_wb_regfile_sb

Overview:
- Receiving end of the write-back interface: integer register file written by the write-back stage (wb_en/wb_idx/wb_data).
- Also a per-register pending-write scoreboard: issue marks a destination pending, write-back retires it.
- Decode reads two source operands and gets a busy flag per operand, used to stall on read-after-write hazards.

Parameters:
- XLEN, 32, register/data width
- RFIDX_W, 5, register index width (2^RFIDX_W registers, x0 hardwired zero)
- SB_CNT_W, 2, per-register pending counter width (max 2^SB_CNT_W-1 in-flight writes per register)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- issue_valid  in  1  an instruction is issuing this cycle
- issue_ready  out  1  issue accepted (destination counter not saturated)
- issue_rd_wen  in  1  issuing instruction writes rd
- issue_rd_idx  in  RFIDX_W  destination index
- wb_en  in  1  write-back strobe (already qualified by stage valid)
- wb_idx  in  RFIDX_W  write-back index
- wb_data  in  XLEN  write-back data
- rs1_idx, rs2_idx  in  RFIDX_W  read indices
- rs1_data, rs2_data  out  XLEN  read data (combinational)
- rs1_busy, rs2_busy  out  1  operand has an outstanding write not yet available
- sb_err  out  1  sticky protocol error

Behaviour:
- Reset (rst high at a clk edge):
  - all registers become 0.
  - all counters become 0.
  - sb_err becomes 0.
  - Outputs after reset: rs*_data=0, rs*_busy=0, issue_ready=1.
  - Reset mid-operation discards every pending count; write-backs in the same cycle as rst are ignored.
- x0: reads always return 0 with busy=0. Writes and issues to x0 never change state.
- Write: on a clk edge with wb_en=1 and wb_idx!=0, reg[wb_idx]<=wb_data. Counter[wb_idx] decrements by 1.
- Issue: fire = issue_valid & issue_ready & issue_rd_wen & (issue_rd_idx!=0). On fire, counter[issue_rd_idx] increments by 1.
- Simultaneous fire and write-back to the same index: counter unchanged; the data write still occurs.
- issue_ready = 0 when counter[issue_rd_idx] is at maximum, unless a write-back to the same index occurs this cycle. Otherwise 1. issue_ready is independent of issue_valid.
- Underflow: a write-back to a register whose counter is 0 (and no simultaneous fire to it) writes the data, leaves the counter at 0, and sets sb_err=1 from the next cycle until reset.
- Read data: combinational from the array, subject to the bypass feature below.
- Busy, without bypass: rsN_busy = counter[rsN_idx]!=0.
- Latency: a write is visible on read ports the cycle after wb_en.

Optional Feature:
- Macro: CORE_RF_WB_BYPASS_EN.
- Defined:
  - Read ports forward wb_data combinationally when wb_en=1, wb_idx==rsN_idx and rsN_idx!=0.
  - rsN_busy = counter!=0, except it is 0 when counter==1 and a write-back to that index occurs this cycle.
  - Result: zero-cycle write-to-read latency.
- Undefined: no forwarding. The same-cycle read returns the old value and busy stays asserted through the write-back cycle.

Decomposition:
- Shared package/defines (core_defines): CORE_XLEN, CORE_RFIDX_WIDTH, SB counter width, ZERO_REG index constant.
- One natural sub-module: core_wb_sb_cnt, a single saturating up/down counter with inc/dec/busy/full/underflow outputs, instantiated per register 1..2^RFIDX_W-1.
- Array storage stays in the top module.

Test Plan:
- Reset, then read rs1=5, rs2=0 -> data 0/0, busy 0/0, issue_ready=1, sb_err=0.
- Issue rd=5; next cycle wb_en, idx=5, data=0xDEADBEEF; rs1_idx=5 throughout ->
  - busy=1 from the cycle after issue.
  - In the wb cycle: with bypass, data=0xDEADBEEF and busy=0; without bypass, old value and busy=1.
  - The cycle after wb: 0xDEADBEEF, busy=0.
- Issue rd=7 three times (SB_CNT_W=2) -> issue_ready=0 on the 4th attempt. Same cycle plus wb idx=7 -> issue_ready=1, counter stays 3. Three further write-backs -> busy clears only after the last.
- wb_en with idx=0, data=0x1234 and issue rd=0 -> rs1_idx=0 reads 0, busy=0, sb_err=0.
- wb_en idx=9 with no prior issue -> reg9 written, busy stays 0, sb_err=1 next cycle and held until rst.
- Issue rd=3 twice, assert rst for one cycle, release -> rs1_idx=3 busy=0, data=0, sb_err=0.

Source files
------------

// File: rtl/core_wb_regfile_sb_pkg.sv
// rtl/core_wb_regfile_sb_pkg.sv - shared widths and constants for the write-back register file
package core_wb_regfile_sb_pkg;

   localparam int CORE_XLEN         = 32;
   localparam int CORE_RFIDX_WIDTH  = 5;
   localparam int CORE_SB_CNT_WIDTH = 2;
   localparam int ZERO_REG          = 0;

   typedef logic [CORE_RFIDX_WIDTH-1:0] core_rfidx_t;
   typedef logic [CORE_XLEN-1:0]        core_xlen_t;

endpackage

// File: rtl/core_wb_regfile_sb_if.sv
// rtl/core_wb_regfile_sb_if.sv - issue, write-back and operand-read bus of the register file
interface core_wb_regfile_sb_if
   import core_wb_regfile_sb_pkg::*;
#(
   parameter int XLEN    = CORE_XLEN,
   parameter int RFIDX_W = CORE_RFIDX_WIDTH
) ();

   logic               issue_valid;
   logic               issue_ready;
   logic               issue_rd_wen;
   logic [RFIDX_W-1:0] issue_rd_idx;
   logic               wb_en;
   logic [RFIDX_W-1:0] wb_idx;
   logic [XLEN-1:0]    wb_data;
   logic [RFIDX_W-1:0] rs1_idx;
   logic [RFIDX_W-1:0] rs2_idx;
   logic [XLEN-1:0]    rs1_data;
   logic [XLEN-1:0]    rs2_data;
   logic               rs1_busy;
   logic               rs2_busy;
   logic               sb_err;

   modport master (
      output issue_valid, issue_rd_wen, issue_rd_idx,
      output wb_en, wb_idx, wb_data,
      output rs1_idx, rs2_idx,
      input  issue_ready, rs1_data, rs2_data, rs1_busy, rs2_busy, sb_err
   );

   modport slave (
      input  issue_valid, issue_rd_wen, issue_rd_idx,
      input  wb_en, wb_idx, wb_data,
      input  rs1_idx, rs2_idx,
      output issue_ready, rs1_data, rs2_data, rs1_busy, rs2_busy, sb_err
   );

endinterface

// File: rtl/core_wb_regfile_sb_cnt.sv
// rtl/core_wb_regfile_sb_cnt.sv - per-register saturating pending-write counter (core_wb_sb_cnt)
module core_wb_sb_cnt #(
   parameter int W = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic dec,
   output logic busy,
   output logic full,
   output logic one,
   output logic underflow
);

   localparam logic [W-1:0] CNT_MAX = '1;
   localparam logic [W-1:0] CNT_ONE = W'(1);

   logic [W-1:0] cnt;

   // inc and dec together cancel, so a full counter may still accept an issue
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (inc && !dec && cnt != CNT_MAX) begin
         cnt <= cnt + CNT_ONE;
      end else if (dec && !inc && cnt != '0) begin
         cnt <= cnt - CNT_ONE;
      end
   end

   assign busy      = (cnt != '0);
   assign full      = (cnt == CNT_MAX);
   assign one       = (cnt == CNT_ONE);
   assign underflow = dec && !inc && (cnt == '0);

endmodule

// File: rtl/core_wb_regfile_sb.sv
// rtl/core_wb_regfile_sb.sv - register file with pending-write scoreboard; CORE_RF_WB_BYPASS_EN enables same-cycle forwarding
module core_wb_regfile_sb
   import core_wb_regfile_sb_pkg::*;
#(
   parameter int XLEN     = CORE_XLEN,
   parameter int RFIDX_W  = CORE_RFIDX_WIDTH,
   parameter int SB_CNT_W = CORE_SB_CNT_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   core_wb_regfile_sb_if.slave   bus
);

   localparam int                 NREG     = 1 << RFIDX_W;
   localparam logic [RFIDX_W-1:0] ZERO_IDX = RFIDX_W'(ZERO_REG);

   logic [XLEN-1:0] regs [NREG];
   logic [NREG-1:0] inc, dec, busy, full, one, uflow;
   logic            wb_hit;
   logic            fire;
   logic            issue_ready;
   logic            sb_err_q;
   logic [XLEN-1:0] rs1_data, rs2_data;
   logic            rs1_busy, rs2_busy;

   assign wb_hit = bus.wb_en && (bus.wb_idx != ZERO_IDX);

   // a write-back to the same index frees a slot this cycle, so a full counter still accepts
   assign issue_ready = !(full[bus.issue_rd_idx] &&
                          !(bus.wb_en && (bus.wb_idx == bus.issue_rd_idx)));

   assign fire = bus.issue_valid && issue_ready && bus.issue_rd_wen &&
                 (bus.issue_rd_idx != ZERO_IDX);

   assign inc[0]   = 1'b0;
   assign dec[0]   = 1'b0;
   assign busy[0]  = 1'b0;
   assign full[0]  = 1'b0;
   assign one[0]   = 1'b0;
   assign uflow[0] = 1'b0;

   for (genvar i = 1; i < NREG; i++) begin : g_sb
      assign inc[i] = fire   && (bus.issue_rd_idx == RFIDX_W'(i));
      assign dec[i] = wb_hit && (bus.wb_idx == RFIDX_W'(i));

      core_wb_sb_cnt #(
         .W (SB_CNT_W)
      ) u_cnt (
         .clk       (clk),
         .rst       (rst),
         .inc       (inc[i]),
         .dec       (dec[i]),
         .busy      (busy[i]),
         .full      (full[i]),
         .one       (one[i]),
         .underflow (uflow[i])
      );
   end

   // regs[0] is cleared by reset and never written, so x0 reads as zero
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (wb_hit) begin
         regs[bus.wb_idx] <= bus.wb_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sb_err_q <= 1'b0;
      end else if (|uflow) begin
         sb_err_q <= 1'b1;
      end
   end

   always_comb begin
      rs1_data = regs[bus.rs1_idx];
      rs2_data = regs[bus.rs2_idx];
      rs1_busy = busy[bus.rs1_idx];
      rs2_busy = busy[bus.rs2_idx];
`ifdef CORE_RF_WB_BYPASS_EN
      if (wb_hit && (bus.wb_idx == bus.rs1_idx)) begin
         rs1_data = bus.wb_data;
         if (one[bus.rs1_idx]) begin
            rs1_busy = 1'b0;
         end
      end
      if (wb_hit && (bus.wb_idx == bus.rs2_idx)) begin
         rs2_data = bus.wb_data;
         if (one[bus.rs2_idx]) begin
            rs2_busy = 1'b0;
         end
      end
`endif
   end

   assign bus.issue_ready = issue_ready;
   assign bus.rs1_data    = rs1_data;
   assign bus.rs2_data    = rs2_data;
   assign bus.rs1_busy    = rs1_busy;
   assign bus.rs2_busy    = rs2_busy;
   assign bus.sb_err      = sb_err_q;

endmodule

// File: tb/tb_core_wb_regfile_sb.sv
// tb/tb_core_wb_regfile_sb.sv - randomized bench for core_wb_regfile_sb against a behavioural model
module tb_core_wb_regfile_sb;

   localparam int NREG = 32;
   localparam int CMAX = 3;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_errors = 0;

   logic [31:0] m_reg [NREG];
   int          m_cnt [NREG];
   bit          m_err;
   bit          m_ok = 1'b0;

   always #5 clk = ~clk;

   core_wb_regfile_sb_if bus ();

   core_wb_regfile_sb dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_data(input int idx, input bit we, input int wi,
                                            input logic [31:0] wd);
      if (idx == 0) return 32'h0;
`ifdef CORE_RF_WB_BYPASS_EN
      if (we && wi == idx) return wd;
`endif
      return m_reg[idx];
   endfunction

   function automatic bit exp_busy(input int idx, input bit we, input int wi);
      if (idx == 0) return 1'b0;
`ifdef CORE_RF_WB_BYPASS_EN
      if (we && wi == idx && m_cnt[idx] == 1) return 1'b0;
`endif
      return m_cnt[idx] != 0;
   endfunction

   task automatic step(input bit r, input bit iv, input bit iw, input int rd,
                       input bit we, input int wi, input logic [31:0] wd,
                       input int r1, input int r2);
      bit ready, fire;
      rst              = r;
      bus.issue_valid  = iv;
      bus.issue_rd_wen = iw;
      bus.issue_rd_idx = 5'(rd);
      bus.wb_en        = we;
      bus.wb_idx       = 5'(wi);
      bus.wb_data      = wd;
      bus.rs1_idx      = 5'(r1);
      bus.rs2_idx      = 5'(r2);
      @(negedge clk);
      ready = !(m_cnt[rd] == CMAX && !(we && wi == rd));
      fire  = iv && ready && iw && rd != 0;
      if (m_ok) begin
         chk("issue_ready", 32'(bus.issue_ready), 32'(ready));
         chk("rs1_data", bus.rs1_data, exp_data(r1, we, wi, wd));
         chk("rs2_data", bus.rs2_data, exp_data(r2, we, wi, wd));
         chk("rs1_busy", 32'(bus.rs1_busy), 32'(exp_busy(r1, we, wi)));
         chk("rs2_busy", 32'(bus.rs2_busy), 32'(exp_busy(r2, we, wi)));
         chk("sb_err", 32'(bus.sb_err), 32'(m_err));
      end
      @(posedge clk);
      if (r) begin
         for (int i = 0; i < NREG; i++) begin
            m_reg[i] = 32'h0;
            m_cnt[i] = 0;
         end
         m_err = 1'b0;
         m_ok  = 1'b1;
      end else begin
         if (we && wi != 0) m_reg[wi] = wd;
         if (fire) m_cnt[rd] = m_cnt[rd] + 1;
         if (we && wi != 0) begin
            if (m_cnt[wi] == 0) m_err = 1'b1;
            else m_cnt[wi] = m_cnt[wi] - 1;
         end
      end
      #1;
   endtask

   initial begin
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 5, 0);

      step(0, 1, 1, 5, 0, 0, 0, 5, 0);
      step(0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 5, 0);
      step(0, 0, 0, 0, 0, 0, 0, 5, 0);

      for (int k = 0; k < 3; k++) step(0, 1, 1, 7, 0, 0, 0, 7, 5);
      step(0, 1, 1, 7, 0, 0, 0, 7, 0);
      step(0, 1, 1, 7, 1, 7, 32'h0000_0077, 7, 0);
      for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 1, 7, 32'h7000_0000 + 32'(k), 7, 0);
      step(0, 0, 0, 0, 0, 0, 0, 7, 0);

      step(0, 1, 1, 0, 1, 0, 32'h1234, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);

      step(0, 0, 0, 0, 1, 9, 32'h9999_0009, 9, 0);
      step(0, 0, 0, 0, 0, 0, 0, 9, 0);
      step(0, 0, 0, 0, 0, 0, 0, 9, 5);

      step(0, 1, 1, 3, 0, 0, 0, 3, 0);
      step(0, 1, 1, 3, 0, 0, 0, 3, 0);
      step(1, 0, 0, 0, 1, 3, 32'hAAAA_5555, 3, 0);
      step(0, 0, 0, 0, 0, 0, 0, 3, 9);

      for (int n = 0; n < 800; n++) begin
         step($urandom_range(0, 63) == 0,
              $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 8, int'($urandom_range(0, 7)),
              $urandom_range(0, 9) < 4, int'($urandom_range(0, 7)), $urandom(),
              int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
